ofifo_drain_acc: RTL and testbench

- Consumer stage directly downstream of the output FIFO of the systolic array.
- Pops complete psum rows (all columns at once) whenever the FIFO reports valid, and accumulates them per row/column over multiple K-passes in an internal accumulator buffer.
- On the final pass it applies an optional ReLU and writes finished rows to the output SRAM write port.

---
 rtl/ofifo_drain_acc.sv | 139 +++++++++++++
 tb/tb_ofifo_drain_acc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_drain_acc.sv
// Drains complete psum rows from the array output FIFO, accumulates them over K-passes
// and writes finished rows (optionally ReLU'd) to the output SRAM on the final pass.
module ofifo_drain_acc #(
  parameter int col    = 8,
  parameter int bw     = 16,
  parameter int depth  = 16,
  parameter int addr_w = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   num_rows,
  input  logic [3:0]          num_pass,
  input  logic                relu_en,
  input  logic                fifo_valid,
  output logic                fifo_rd,
  input  logic [col*bw-1:0]   fifo_out,
  output logic                wr_en,
  output logic [addr_w-1:0]   wr_addr,
  output logic [col*bw-1:0]   wr_data,
  output logic                busy,
  output logic                done
);

  // state   | meaning
  // IDLE    | waiting for start
  // ISSUE   | pop a row as soon as the FIFO reports valid
  // CAPTURE | popped row on fifo_out; accumulate / prepare write
  // DONE    | one-cycle completion pulse, last write strobed
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [addr_w-1:0] row_cnt, num_rows_q;
  logic [3:0]        pass_cnt, num_pass_q;
  logic              relu_q;
  logic              last_row, last_pass;

  logic [col*bw-1:0] acc [depth];
  logic [col*bw-1:0] acc_rd, sum_row, out_row;

  assign last_row  = (row_cnt == num_rows_q);
  assign last_pass = (pass_cnt == num_pass_q);
  assign acc_rd    = acc[row_cnt];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (fifo_valid) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (last_row && last_pass) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ISSUE:   begin fifo_rd = fifo_valid; busy = 1'b1; end
      CAPTURE: busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Per-lane add at bw+1 bits, then clamp; ReLU only affects the written copy.
  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [bw-1:0] in_l, acc_l, sat_l;
    logic [bw:0]   ext_l;
    assign in_l  = fifo_out[i*bw +: bw];
    assign acc_l = acc_rd[i*bw +: bw];
    assign ext_l = (pass_cnt == 4'd0) ? {in_l[bw-1], in_l}
                 : {acc_l[bw-1], acc_l} + {in_l[bw-1], in_l};
    assign sat_l = (ext_l[bw] != ext_l[bw-1]) ? {ext_l[bw], {(bw-1){~ext_l[bw]}}}
                 : ext_l[bw-1:0];
    assign sum_row[i*bw +: bw] = sat_l;
    assign out_row[i*bw +: bw] = (relu_q && sat_l[bw-1]) ? '0 : sat_l;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt    <= '0;
      pass_cnt   <= '0;
      num_rows_q <= '0;
      num_pass_q <= '0;
      relu_q     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_rows_q <= num_rows;
            num_pass_q <= num_pass;
            relu_q     <= relu_en;
            row_cnt    <= '0;
            pass_cnt   <= '0;
          end
        end
        CAPTURE: begin
          if (last_pass) begin
            wr_en   <= 1'b1;
            wr_addr <= row_cnt;
            wr_data <= out_row;
          end
          if (last_row) begin
            row_cnt  <= '0;
            pass_cnt <= pass_cnt + 4'd1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Accumulator needs no reset; pass 0 overwrites every row it uses.
  always_ff @(posedge clk) begin
    if (!reset && state == CAPTURE && !last_pass)
      acc[row_cnt] <= sum_row;
  end

endmodule

// File: tb/tb_ofifo_drain_acc.sv
// Directed bench for ofifo_drain_acc: FIFO row model, write logger and
// hand-computed expectations checked with immediate assertions.
module tb_ofifo_drain_acc;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, relu_en, fifo_valid;
  logic [AW-1:0] num_rows;
  logic [3:0]    num_pass;
  logic [127:0]  fifo_out = '0;
  logic          fifo_rd, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [127:0]  wr_data;

  ofifo_drain_acc dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .num_pass(num_pass),
    .relu_en(relu_en), .fifo_valid(fifo_valid), .fifo_rd(fifo_rd), .fifo_out(fifo_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, pop_idx = 0, rd_cnt = 0, wr_n = 0, done_cyc = -1;
  logic clr = 1'b0;
  logic [127:0]  rows [16];
  logic [AW-1:0] log_addr [16];
  logic [127:0]  log_data [16];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      pop_idx <= 0; rd_cnt <= 0; wr_n <= 0;
    end else begin
      if (fifo_rd) begin
        fifo_out <= rows[pop_idx % 16];
        pop_idx  <= pop_idx + 1;
        rd_cnt   <= rd_cnt + 1;
      end
      if (wr_en) begin
        log_addr[wr_n % 16] <= wr_addr;
        log_data[wr_n % 16] <= wr_data;
        wr_n <= wr_n + 1;
      end
    end
    if (done) done_cyc <= cyc;
  end

  function automatic logic [127:0] rep(input logic [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [127:0] split(input logic [15:0] lo, input logic [15:0] hi);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = (i < 4) ? lo : hi;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic start_job(input logic [AW-1:0] nr, input logic [3:0] np, input logic re,
                           output int sc);
    start = 1'b1; num_rows = nr; num_pass = np; relu_en = re; sc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    logic got;
    got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    chk("done_seen", got, 1'b1);
    step();
  endtask

  logic [127:0] lanes18;
  int sc, r0;

  initial begin
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; fifo_valid = 1'b0;
    num_rows = '0; num_pass = '0;
    for (int i = 0; i < 8; i++) lanes18[i*16 +: 16] = 16'(i + 1);
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_addr", wr_addr, 4'd0);
    chk("rst_wr_data", wr_data, 128'd0);
    step();
    reset = 1'b0;
    step();

    // single row, single pass, exact cycle timeline
    clear();
    rows[0] = lanes18; fifo_valid = 1'b1;
    start = 1'b1; num_rows = 4'd0; num_pass = 4'd0; relu_en = 1'b0;
    @(negedge clk); chk("t1_rd_c0", fifo_rd, 1'b0);
    step(); start = 1'b0;
    @(negedge clk); chk("t1_rd_c1", fifo_rd, 1'b1); chk("t1_busy_c1", busy, 1'b1);
    step();
    @(negedge clk); chk("t1_rd_c2", fifo_rd, 1'b0);
    step();
    @(negedge clk);
    chk("t1_wr_en", wr_en, 1'b1); chk("t1_wr_addr", wr_addr, 4'd0);
    chk("t1_wr_data", wr_data, lanes18); chk("t1_done", done, 1'b1);
    step();
    @(negedge clk);
    chk("t1_busy_c4", busy, 1'b0); chk("t1_wr_en_c4", wr_en, 1'b0); chk("t1_done_c4", done, 1'b0);
    step();

    // two passes, two rows
    clear();
    rows[0] = rep(16'd10); rows[1] = rep(16'hFFEC); rows[2] = rep(16'd5); rows[3] = rep(16'd30);
    start_job(4'd1, 4'd1, 1'b0, sc);
    wait_done(40);
    chk("t2_latency", 32'(done_cyc - sc), 32'd9);
    chk("t2_wr_count", wr_n, 32'd2);
    chk("t2_addr0", log_addr[0], 4'd0); chk("t2_data0", log_data[0], rep(16'd15));
    chk("t2_addr1", log_addr[1], 4'd1); chk("t2_data1", log_data[1], rep(16'd10));
    chk("t2_rd_count", rd_cnt, 32'd4);

    // saturation, then saturation with ReLU
    clear();
    rows[0] = split(16'h7000, 16'h9000); rows[1] = split(16'h7000, 16'h9000);
    start_job(4'd0, 4'd1, 1'b0, sc);
    wait_done(40);
    chk("t3_wr_count", wr_n, 32'd1);
    chk("t3_sat", log_data[0], split(16'h7FFF, 16'h8000));
    clear();
    start_job(4'd0, 4'd1, 1'b1, sc);
    wait_done(40);
    chk("t3_sat_relu", log_data[0], split(16'h7FFF, 16'h0000));

    // five-cycle FIFO stall after the first capture
    clear();
    rows[0] = rep(16'd100); rows[1] = rep(16'd200); rows[2] = rep(16'd300);
    start_job(4'd2, 4'd0, 1'b0, sc);
    step(); fifo_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("t4_stall_rd", fifo_rd, 1'b0);
      chk("t4_stall_busy", busy, 1'b1);
    end
    step(); fifo_valid = 1'b1;
    wait_done(40);
    chk("t4_latency", 32'(done_cyc - sc), 32'd12);
    chk("t4_wr_count", wr_n, 32'd3);
    chk("t4_data0", log_data[0], rep(16'd100));
    chk("t4_addr2", log_addr[2], 4'd2); chk("t4_data2", log_data[2], rep(16'd300));

    // reset during pass 1, row 3 of 4
    clear();
    for (int i = 0; i < 8; i++) rows[i] = rep(16'(i + 1));
    start_job(4'd3, 4'd1, 1'b0, sc);
    repeat (14) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("t5_busy", busy, 1'b0); chk("t5_fifo_rd", fifo_rd, 1'b0);
    chk("t5_wr_en", wr_en, 1'b0); chk("t5_done", done, 1'b0);
    r0 = rd_cnt;
    chk("t5_pops_before", r0, 32'd8);
    step(); reset = 1'b0;
    repeat (3) step();
    chk("t5_no_pop_after", rd_cnt, r0);
    clear();
    rows[0] = rep(16'hFFF9);
    start_job(4'd0, 4'd0, 1'b0, sc);
    wait_done(40);
    chk("t5_fresh_latency", 32'(done_cyc - sc), 32'd3);
    chk("t5_fresh_count", wr_n, 32'd1);
    chk("t5_fresh_data", log_data[0], rep(16'hFFF9));

    // start pulses while busy (mid-job and in DONE) are ignored
    clear();
    rows[0] = rep(16'd1); rows[1] = rep(16'd2);
    start_job(4'd1, 4'd0, 1'b0, sc);
    step(); start = 1'b1; num_rows = 4'd5;
    step(); start = 1'b0;
    step();
    step(); start = 1'b1;
    @(negedge clk); chk("t6_done_c5", done, 1'b1);
    step(); start = 1'b0;
    @(negedge clk); chk("t6_busy_c6", busy, 1'b0);
    step();
    @(negedge clk); chk("t6_busy_c7", busy, 1'b0);
    chk("t6_wr_count", wr_n, 32'd2);
    chk("t6_rd_count", rd_cnt, 32'd2);
    chk("t6_addr1", log_addr[1], 4'd1); chk("t6_data1", log_data[1], rep(16'd2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
